// File: rtl/composite_pkg.sv
// Shared level codes, clock rate and read-FSM state type for the composite line buffer.
package composite_pkg;

  localparam logic [1:0] LEVEL_SYNC  = 2'b00;
  localparam logic [1:0] LEVEL_BLACK = 2'b01;
  localparam logic [1:0] LEVEL_GRAY  = 2'b10;
  localparam logic [1:0] LEVEL_WHITE = 2'b11;

  localparam int unsigned CLK_SPEED = 27_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StBorder,
    StPixels
  } read_state_e;

  // Stored data may never pull the output down to sync level.
  function automatic logic [1:0] level_fix(input logic [1:0] code);
    return (code == LEVEL_SYNC) ? LEVEL_BLACK : code;
  endfunction

endpackage

// File: rtl/composite_line_ram.sv
// Two-bank 2 x 256 x 2-bit line store: one write port, one registered read port.
module composite_line_ram (
  input  logic       i_clk,
  input  logic       i_wr_en,
  input  logic [8:0] i_wr_addr,
  input  logic [1:0] i_wr_data,
  input  logic [8:0] i_rd_addr,
  output logic [1:0] o_rd_data
);

  logic [1:0] r_mem [0:511];
  logic [1:0] r_rd_data;

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/composite_line_buffer.sv
// Double-buffered luma line store serializing one line per render window to the sync/DAC
// generator. Optional bar test pattern: define COMPOSITE_TEST_PATTERN_EN.
module composite_line_buffer
  import composite_pkg::*;
#(
  parameter int unsigned PIXEL_COUNT  = 256,
  parameter int unsigned PIXEL_CYCLES = 6,
  parameter int unsigned LEFT_BORDER  = 26
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_valid,
  input  logic [1:0] i_wr_data,
  output logic       o_wr_ready,
  input  logic       i_render_start,
`ifdef COMPOSITE_TEST_PATTERN_EN
  input  logic       i_pattern_sel,
`endif
  output logic [1:0] o_pixel_level,
  output logic       o_pixel_active,
  output logic       o_underrun
);

  localparam logic [7:0] IdxLast    = 8'(PIXEL_COUNT - 1);
  localparam logic [3:0] CycLast    = 4'(PIXEL_CYCLES - 1);
  // The render_start cycle counts as the first border clock; two more cover read latency.
  localparam logic [7:0] BorderLast = 8'(LEFT_BORDER - 2);

  // Write side and bank control
  logic       r_bank_sel;
  logic       r_back_full;
  logic       r_front_valid;
  logic       r_underrun;
  logic [7:0] r_wr_idx;
  logic       w_wr_fire;

  assign o_wr_ready = !r_back_full && !i_reset;
  assign w_wr_fire  = i_wr_valid && o_wr_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bank_sel    <= 1'b0;
      r_back_full   <= 1'b0;
      r_front_valid <= 1'b0;
      r_underrun    <= 1'b0;
      r_wr_idx      <= 8'd0;
    end else begin
      // A write can only fire while back_full is clear, so it never races a swap.
      if (i_render_start) begin
        if (r_back_full) begin
          r_bank_sel    <= ~r_bank_sel;
          r_front_valid <= 1'b1;
          r_back_full   <= 1'b0;
        end else begin
          r_underrun <= 1'b1;
        end
      end
      if (w_wr_fire) begin
        if (r_wr_idx == IdxLast) begin
          r_wr_idx    <= 8'd0;
          r_back_full <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 8'd1;
        end
      end
    end
  end

  // Read FSM
  read_state_e r_state, w_state;
  logic [7:0]  r_border_cnt, w_border_cnt;
  logic [3:0]  r_cyc_cnt, w_cyc_cnt;
  logic [7:0]  r_pix_idx, w_pix_idx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_border_cnt <= 8'd0;
      r_cyc_cnt    <= 4'd0;
      r_pix_idx    <= 8'd0;
    end else begin
      r_state      <= w_state;
      r_border_cnt <= w_border_cnt;
      r_cyc_cnt    <= w_cyc_cnt;
      r_pix_idx    <= w_pix_idx;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_border_cnt = r_border_cnt;
    w_cyc_cnt    = r_cyc_cnt;
    w_pix_idx    = r_pix_idx;
    case (r_state)
      StIdle: ;
      StBorder: begin
        if (r_border_cnt == BorderLast) begin
          w_state   = StPixels;
          w_cyc_cnt = 4'd0;
          w_pix_idx = 8'd0;
        end else begin
          w_border_cnt = r_border_cnt + 8'd1;
        end
      end
      StPixels: begin
        if (r_cyc_cnt == CycLast) begin
          w_cyc_cnt = 4'd0;
          if (r_pix_idx == IdxLast) begin
            w_state = StIdle;
          end else begin
            w_pix_idx = r_pix_idx + 8'd1;
          end
        end else begin
          w_cyc_cnt = r_cyc_cnt + 4'd1;
        end
      end
      default: w_state = StIdle;
    endcase
    if (i_render_start) begin
      w_state      = StBorder;
      w_border_cnt = 8'd0;
    end
  end

  // Line RAM: the bank select is the address MSB; the front bank is the one selected.
  logic [1:0] w_ram_q;

  composite_line_ram u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_fire),
    .i_wr_addr ({~r_bank_sel, r_wr_idx}),
    .i_wr_data (i_wr_data),
    .i_rd_addr ({r_bank_sel, r_pix_idx}),
    .o_rd_data (w_ram_q)
  );

  // Stage 1 travels alongside the RAM read; stage 2 is the output register.
  logic       r_s1_pix;
  logic       r_s1_front;
  logic [1:0] r_pixel_level;
  logic       r_pixel_active;
  logic [1:0] w_level;
  logic       w_active;

`ifdef COMPOSITE_TEST_PATTERN_EN
  logic       r_s1_pat;
  logic [1:0] r_s1_pat_level;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_pat       <= 1'b0;
      r_s1_pat_level <= LEVEL_BLACK;
    end else begin
      r_s1_pat       <= (r_state == StPixels) && i_pattern_sel;
      r_s1_pat_level <= r_pix_idx[7] ? {1'b1, r_pix_idx[6]} : LEVEL_BLACK;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_pix   <= 1'b0;
      r_s1_front <= 1'b0;
    end else begin
      r_s1_pix   <= (r_state == StPixels);
      r_s1_front <= r_front_valid;
    end
  end

  always_comb begin
    w_level  = LEVEL_BLACK;
    w_active = 1'b0;
    if (r_s1_pix && r_s1_front) begin
      w_active = 1'b1;
      w_level  = level_fix(w_ram_q);
    end
`ifdef COMPOSITE_TEST_PATTERN_EN
    if (r_s1_pix) begin
      w_active = 1'b1;
    end
    if (r_s1_pat) begin
      w_level = r_s1_pat_level;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pixel_level  <= LEVEL_BLACK;
      r_pixel_active <= 1'b0;
    end else begin
      r_pixel_level  <= w_level;
      r_pixel_active <= w_active;
    end
  end

  assign o_pixel_level  = r_pixel_level;
  assign o_pixel_active = r_pixel_active;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_composite_line_buffer.sv
// Directed bench for composite_line_buffer: write/swap/replay, underrun, restart and backpressure.
module tb_composite_line_buffer;
  import composite_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [1:0] wr_data;
  logic       wr_ready;
  logic       render_start;
  logic [1:0] pixel_level;
  logic       pixel_active;
  logic       underrun;
`ifdef COMPOSITE_TEST_PATTERN_EN
  logic       pattern_sel;
  localparam logic NoFrontActive = 1'b1;
`else
  localparam logic NoFrontActive = 1'b0;
`endif

  composite_line_buffer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_wr_valid     (wr_valid),
    .i_wr_data      (wr_data),
    .o_wr_ready     (wr_ready),
    .i_render_start (render_start),
`ifdef COMPOSITE_TEST_PATTERN_EN
    .i_pattern_sel  (pattern_sel),
`endif
    .o_pixel_level  (pixel_level),
    .o_pixel_active (pixel_active),
    .o_underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  function automatic logic [1:0] pix(input int mode, input int i);
    logic [1:0] r;
    r = 2'(i % 4);
    if (mode == 0) begin
      case (r)
        2'd0:    return LEVEL_BLACK;
        2'd1:    return LEVEL_GRAY;
        default: return LEVEL_WHITE;
      endcase
    end
    return r;
  endfunction

  task automatic write_pixels(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = pix(mode, i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start(output int t);
    render_start = 1'b1;
    t = cyc;
    tick();
    render_start = 1'b0;
  endtask

  int t, n_xfer;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = 2'b00; render_start = 1'b0;
`ifdef COMPOSITE_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    tick();
    tick();
    check("ready_in_reset", wr_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_level", pixel_level, 2'b01);
    check("rst_active", pixel_active, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", wr_ready, 1'b1);

    // No line written yet: underrun, front invalid
    pulse_start(t);
    check("nofront_underrun", underrun, 1'b1);
    wait_until(t + 28);
    check("nofront_level28", pixel_level, 2'b01);
    check("nofront_active28", pixel_active, NoFrontActive);
    wait_until(t + 100);
    check("nofront_level100", pixel_level, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midline_rst_active", pixel_active, 1'b0);
    check("midline_rst_underrun", underrun, 1'b0);

    // Full line, then swap
    write_pixels(256, 0);
    check("ready_after_full", wr_ready, 1'b0);
    pulse_start(t);
    check("ready_after_swap", wr_ready, 1'b1);
    wait_until(t + 27);
    check("l1_active27", pixel_active, 1'b0);
    wait_until(t + 28);
    check("l1_p0_level", pixel_level, 2'b01);
    check("l1_p0_active", pixel_active, 1'b1);
    wait_until(t + 33);
    check("l1_p0_end", pixel_level, 2'b01);
    wait_until(t + 34);
    check("l1_p1_start", pixel_level, 2'b10);
    wait_until(t + 39);
    check("l1_p1_end", pixel_level, 2'b10);
    wait_until(t + 40);
    check("l1_p2", pixel_level, 2'b11);
    wait_until(t + 1563);
    check("l1_p255_level", pixel_level, 2'b11);
    check("l1_p255_active", pixel_active, 1'b1);
    wait_until(t + 1564);
    check("l1_end_active", pixel_active, 1'b0);
    check("l1_end_level", pixel_level, 2'b01);
    check("l1_underrun", underrun, 1'b0);

    // Last write coincides with render_start: no swap, front replays
    write_pixels(255, 1);
    wr_valid = 1'b1;
    wr_data  = 2'd3;
    pulse_start(t);
    wr_valid = 1'b0;
    check("race_ready", wr_ready, 1'b0);
    check("race_underrun", underrun, 1'b1);
    wait_until(t + 34);
    check("race_replay_p1", pixel_level, 2'b10);
    wait_until(t + 1564);
    pulse_start(t);
    check("race_swap_ready", wr_ready, 1'b1);
    wait_until(t + 28);
    check("l2_p0_sync_remap", pixel_level, 2'b01);
    wait_until(t + 34);
    check("l2_p1", pixel_level, 2'b01);
    wait_until(t + 40);
    check("l2_p2", pixel_level, 2'b10);
    wait_until(t + 46);
    check("l2_p3", pixel_level, 2'b11);

    // Restart mid-line at T+500
    wait_until(t + 500);
    pulse_start(t);
    wait_until(t + 10);
    check("restart_border_active", pixel_active, 1'b0);
    wait_until(t + 28);
    check("restart_p0_active", pixel_active, 1'b1);
    wait_until(t + 46);
    check("restart_p3", pixel_level, 2'b11);
    wait_until(t + 1563);
    check("restart_p255_active", pixel_active, 1'b1);
    wait_until(t + 1564);
    check("restart_end_active", pixel_active, 1'b0);

    // Backpressure: wr_valid held for two lines' worth of cycles
    n_xfer = 0;
    for (int i = 0; i < 600; i++) begin
      wr_valid = 1'b1;
      wr_data  = (n_xfer < 256) ? 2'b10 : 2'b00;
      if (wr_ready) n_xfer++;
      tick();
    end
    wr_valid = 1'b0;
    check("bp_transfers", n_xfer, 256);
    check("bp_ready", wr_ready, 1'b0);
    pulse_start(t);
    wait_until(t + 28);
    check("bp_p0", pixel_level, 2'b10);
    wait_until(t + 1563);
    check("bp_p255", pixel_level, 2'b10);
    wait_until(t + 1564);
    check("bp_end_active", pixel_active, 1'b0);

`ifdef COMPOSITE_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    pulse_start(t);
    wait_until(t + 28);
    check("pat_p0_level", pixel_level, 2'b01);
    check("pat_p0_active", pixel_active, 1'b1);
    wait_until(t + 796);
    check("pat_p128", pixel_level, 2'b10);
    wait_until(t + 1180);
    check("pat_p192", pixel_level, 2'b11);
    wait_until(t + 1564);
    pattern_sel = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/composite_line_buffer.md
# composite_line_buffer

Double-buffered luma line store feeding the composite sync/DAC generator. An upstream writer streams one line of 2-bit pixel levels into the back bank while the front bank is serialized, one pixel every `PIXEL_CYCLES` clocks, to the generator during its render window. Banks swap only at the generator's `render_start` pulse, so a line is never torn.

## Interface
- `PIXEL_COUNT`, 256: pixels per line, at most 256.
- `PIXEL_CYCLES`, 6: clocks per pixel, at most 15. At 27 MHz, 256 × 6 = 1536 cycles, which fits the 1589-cycle render window.
- `LEFT_BORDER`, 26: black clocks between `render_start` and pixel 0.
- `clk`  in  1: 27 MHz system clock.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `wr_valid`  in  1: writer has a pixel.
- `wr_data`  in  2: pixel level code.
- `wr_ready`  out  1: back bank can accept a pixel.
- `render_start`  in  1: single-cycle pulse from the sync generator on entry to render.
- `pixel_level`  out  2: level code to the generator. Bit 1 drives the 450 Ω output; bit 0 drives the 900 Ω output.
- `pixel_active`  out  1: `pixel_level` carries buffer data.
- `underrun`  out  1: sticky; a line started with the back bank not full.

## Operation
- Level codes: 00 sync, 01 black, 10 gray, 11 white. `pixel_level` is always registered and idles at 01. Code 00 is never emitted. A written 00 is emitted as 01.
- Write side:
  - An 8-bit write index `wr_idx` and a `back_full` flag.
  - `wr_ready = !back_full && !reset`.
  - A transfer occurs on `wr_valid && wr_ready` and stores `wr_data` at `wr_idx` in the back bank, then increments `wr_idx`.
  - The transfer at `wr_idx == PIXEL_COUNT-1` sets `back_full` and clears `wr_idx`.
- Swap, on `render_start`, evaluated on registered `back_full` before any same-cycle write:
  - If `back_full` is set: toggle the bank select, set `front_valid`, clear `back_full`.
  - Otherwise: keep the front bank (it is replayed if valid), set `underrun`.
- A write completing on the same cycle as `render_start` does not swap that line. It swaps at the next `render_start`.
- Read FSM states:
  - IDLE: `pixel_level` = 01, `pixel_active` = 0.
  - BORDER: counts `LEFT_BORDER` clocks.
  - PIXELS: 4-bit cycle counter plus 8-bit pixel index; RAM read is registered with 1-cycle latency.
  - Return to IDLE after pixel `PIXEL_COUNT-1` has been held for `PIXEL_CYCLES` clocks.
- `render_start` in any state restarts BORDER; the current line is abandoned.
- With `front_valid` = 0, PIXELS runs but emits 01, and `pixel_active` stays 0.
- Reset values: `wr_idx` = 0, `back_full` = 0, `front_valid` = 0, bank select = 0, state IDLE, `underrun` = 0, `pixel_level` = 01, `pixel_active` = 0. RAM contents are not reset.
- Reset mid-line returns to IDLE on the next clock.

## Timing
- `render_start` at cycle T: pixel k is on `pixel_level` for cycles T+2+`LEFT_BORDER`+k·`PIXEL_CYCLES` through that value + `PIXEL_CYCLES`−1.
- With defaults, `pixel_active` is high from T+28 to T+1563 inclusive (1536 cycles). `pixel_level` returns to 01 at T+1564.
- Write throughput: one pixel per clock. `wr_ready` falls the cycle after the last transfer and rises the cycle after a swapping `render_start`.

## Configuration
- `COMPOSITE_TEST_PATTERN_EN`, when defined:
  - Adds input `pattern_sel` (1 bit).
  - While `pattern_sel` = 1, PIXELS emits code {1, pixel index[6]} for pixel index[7] = 1, else 01. This gives black/gray/white bars.
  - `pixel_active` = 1 during PIXELS regardless of `front_valid`.
  - The write path is unaffected.
- Undefined: no port, no pattern logic.

## Structure
- Package `composite_pkg`:
  - Level codes `LEVEL_SYNC`, `LEVEL_BLACK`, `LEVEL_GRAY`, `LEVEL_WHITE`.
  - `CLK_SPEED` = 27_000_000.
  - Read-FSM state enum.
- One sub-module, `composite_line_ram`: 2 × 256 × 2-bit, one write port, one registered read port, bank select as the address MSB.

## Test plan
- Reset, write 256 pixels (index mod 4 mapped to 01/10/11/11), `render_start` at T → `wr_ready` low after the 256th transfer and high at T+1. Pixel 0 = 01 at T+28. Pixel 1 = 10 from T+34 to T+39. `pixel_active` low at T+1564.
- `render_start` with no line written since reset → `underrun` = 1, `pixel_level` stays 01, `pixel_active` stays 0.
- Write 255 pixels, then the 256th on the same cycle as `render_start` → no swap, `underrun` set. Next `render_start` swaps and emits the new line.
- Second `render_start` at T+500 mid-line → pixel 0 restarts at T+528, and the line completes normally from there.
- `wr_valid` held high across two lines with no `render_start` → exactly 256 transfers accepted, `wr_ready` stays 0, back-bank data unchanged.
- `COMPOSITE_TEST_PATTERN_EN` defined, `pattern_sel` = 1, `render_start` at T → pixel 128 = 10, pixel 192 = 11, pixel 0 = 01; `pixel_active` high from T+28.
